// File: rtl/data_cache_pkg.sv
// Geometry and FSM state encodings shared by the data cache and its controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package data_cache_pkg;

  localparam int NUM_SETS = 8;
  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int BYTE_W   = 8;
  localparam int BLOCK_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FETCH     = 2'd2,
    ST_UPDATE    = 2'd3
  } state_t;

endpackage

// File: rtl/cache_controller_fsm.sv
// Miss-handling controller: write back a dirty victim, fetch the new block, then refill.
// Latency: the miss is detected combinationally; one edge to leave IDLE, memory-paced WB/FETCH, one UPDATE cycle.
// Backpressure: stalls the CPU via o_busywait; waits in WB/FETCH while memory raises i_mem_busywait.
module cache_controller_fsm
  import data_cache_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic i_access,
  input  logic i_hit,
  input  logic i_dirty,
  input  logic i_mem_busywait,
  output logic o_busywait,
  output logic o_mem_read,
  output logic o_mem_write,
  output logic o_update
);

  state_t r_state;
  state_t w_next;

  // State register; reset abandons any memory transaction in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and outputs; everything is held low while reset is asserted.
  always_comb begin
    w_next      = r_state;
    o_busywait  = 1'b0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_update    = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_IDLE: begin
          if (i_access && !i_hit) begin
            o_busywait = 1'b1;
            w_next     = i_dirty ? ST_WRITEBACK : ST_FETCH;
          end
        end
        ST_WRITEBACK: begin
          o_busywait  = 1'b1;
          o_mem_write = 1'b1;
          if (!i_mem_busywait) w_next = ST_FETCH;
        end
        ST_FETCH: begin
          o_busywait = 1'b1;
          o_mem_read = 1'b1;
          if (!i_mem_busywait) w_next = ST_UPDATE;
        end
        ST_UPDATE: begin
          o_busywait = 1'b1;
          o_update   = 1'b1;
          w_next     = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped 8-set write-back byte cache with 4-byte blocks.
// Latency: read hits return data in the same cycle; write hits commit at the next edge.
// Backpressure: busywait stalls the CPU on a miss until the refilled block is in place.
module data_cache
  import data_cache_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 read,
  input  logic                 write,
  input  logic [7:0]           address,
  input  logic [7:0]           writedata,
  output logic [7:0]           readdata,
  output logic                 busywait,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [5:0]           mem_address,
  output logic [BLOCK_W-1:0]   mem_writedata,
  input  logic [BLOCK_W-1:0]   mem_readdata,
  input  logic                 mem_busywait
);

  logic [BLOCK_W-1:0] r_data [NUM_SETS];
  logic [TAG_W-1:0]   r_tag  [NUM_SETS];
  logic [NUM_SETS-1:0] r_valid;
  logic [NUM_SETS-1:0] r_dirty;

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_index;
  logic [OFFSET_W-1:0] w_offset;
  logic                w_access;
  logic                w_hit;
  logic                w_dirty;
  logic                w_update;
  logic                w_write_hit;

  assign w_tag    = address[7:5];
  assign w_index  = address[4:2];
  assign w_offset = address[1:0];

  // Read and write together is treated as no access at all.
  assign w_access    = read ^ write;
  assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_dirty     = r_valid[w_index] && r_dirty[w_index];
  assign w_write_hit = write && !read && w_hit && !busywait && !reset;

  cache_controller_fsm u_fsm (
    .clock          (clock),
    .reset          (reset),
    .i_access       (w_access),
    .i_hit          (w_hit),
    .i_dirty        (w_dirty),
    .i_mem_busywait (mem_busywait),
    .o_busywait     (busywait),
    .o_mem_read     (mem_read),
    .o_mem_write    (mem_write),
    .o_update       (w_update)
  );

  // Write-back uses the victim's stored tag; the fetch uses the CPU's tag.
  assign mem_address   = mem_write ? {r_tag[w_index], w_index} : {w_tag, w_index};
  assign mem_writedata = r_data[w_index];

  // Read data only on an IDLE read hit; zero otherwise.
  assign readdata = (read && !write && w_hit && !busywait && !reset)
                    ? r_data[w_index][{w_offset, 3'b000} +: BYTE_W]
                    : '0;

  // Valid/dirty bookkeeping; reset invalidates everything and drops dirty data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_update) begin
      r_valid[w_index] <= 1'b1;
      r_dirty[w_index] <= 1'b0;
    end else if (w_write_hit) begin
      r_dirty[w_index] <= 1'b1;
    end
  end

  // Data and tag arrays: refill on UPDATE, single-byte store on a write hit.
  always_ff @(posedge clock) begin
    if (w_update) begin
      r_data[w_index] <= mem_readdata;
      r_tag[w_index]  <= w_tag;
    end else if (w_write_hit) begin
      r_data[w_index][{w_offset, 3'b000} +: BYTE_W] <= writedata;
    end
  end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed: 8 sets, direct-mapped, 4-byte blocks, tag 3 bits, index 3 bits, offset 2 bits.
REQ-002 The ports SHALL be (name, direction, width, meaning):
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- read  in  1  CPU byte-read request.
- write  in  1  CPU byte-write request.
- address  in  8  CPU byte address: [7:5] tag, [4:2] index, [1:0] offset.
- writedata  in  8  CPU write byte.
- readdata  out  8  CPU read byte.
- busywait  out  1  CPU stall request.
- mem_read  out  1  memory block-read request.
- mem_write  out  1  memory block-write request.
- mem_address  out  6  memory block address, {tag,index}.
- mem_writedata  out  32  write-back block.
- mem_readdata  in  32  fetched block.
- mem_busywait  in  1  memory busy.

Function
REQ-003 Per set: 32-bit data block, 3-bit tag, valid bit, dirty bit; byte offset n SHALL map to block bits [8n+7:8n].
REQ-004 hit SHALL be valid[index] AND tag[index]==address[7:5], combinational.
REQ-005 Access SHALL be read XOR write; read and write both high SHALL be treated as no access (busywait 0, no state change).
REQ-006 FSM states SHALL be IDLE, WRITEBACK, FETCH, UPDATE.
REQ-007 busywait SHALL be 1 when state!=IDLE, or when in IDLE with an access and no hit; otherwise 0 (combinational).
REQ-008 Read hit in IDLE: readdata SHALL be the addressed byte in the same cycle (zero extra cycles); otherwise readdata SHALL be 8'h00.
REQ-009 Write hit in IDLE: the byte SHALL be stored at the next rising edge, with dirty set to 1.
REQ-010 IDLE miss: the FSM SHALL move to WRITEBACK if valid&dirty, else FETCH, at the next edge.
REQ-011 WRITEBACK SHALL drive mem_write=1, mem_address={stored tag,index}, and mem_writedata=stored block; the FSM SHALL move to FETCH on the first edge with mem_busywait=0.
REQ-012 FETCH SHALL drive mem_read=1 and mem_address={address[7:5],index}; the FSM SHALL move to UPDATE on the first edge with mem_busywait=0.
REQ-013 UPDATE SHALL last one cycle with mem_read=mem_write=0, and at its closing edge SHALL load block=mem_readdata, tag, valid=1, dirty=0; the FSM then enters IDLE, where the pending access hits and completes per REQ-008/009.
REQ-014 mem_read and mem_write SHALL never both be 1; both SHALL be 0 in IDLE and UPDATE.
REQ-015 CPU address and data SHALL be held stable while busywait=1; the cache does not latch them.

Reset
REQ-016 Asserting reset SHALL immediately force: state IDLE; all valid and dirty bits 0; busywait 0; mem_read 0; mem_write 0; readdata 8'h00.
REQ-017 Reset mid-WRITEBACK/FETCH SHALL abandon the transaction with no update; dirty data is lost.
REQ-018 Data and tag arrays need not be cleared.

Structure
REQ-019 A shared header SHALL hold the geometry constants (set count, tag/index/offset widths) and the state encodings.
REQ-020 The FSM SHALL be the sole sub-module, cache_controller_fsm; the arrays and hit logic stay in data_cache.

Verification
REQ-021 Reset, then read 0x25 -> busywait=1, mem_read=1, mem_address=6'h09; memory returns 32'hDDCCBBAA -> UPDATE, then readdata=8'hBB, busywait=0.
REQ-022 Next, write 0x26 with data 0x5A -> busywait stays 0; next cycle, read 0x26 -> 8'h5A with no mem_read.
REQ-023 Next, read 0x45 -> mem_write=1, mem_address=6'h09, mem_writedata=32'hDD5ABBAA; then mem_read=1, mem_address=6'h11.
REQ-024 Reset, then write 0x80 with data 0x11 -> FETCH of 6'h20 with no WRITEBACK; after completion, byte 0 = 0x11 and the set is dirty.
REQ-025 Assert reset during FETCH -> mem_read=0 and busywait=0 at once; a re-read of the same address misses again.
REQ-026 read=write=1 -> busywait=0, no memory request, arrays unchanged.
